// File: rtl/fire_pkg.sv
// Shared definitions for the fire layer output path: default activation
// width, the OFM writer state encoding, and the OFM RAM address-width rule
// (also used by the RAM wrapper, so both sides always agree).
package fire_pkg;

  localparam int OFM_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    WAIT_FIN = 2'd2,
    DONE     = 2'd3
  } writer_state_e;

  // Address bits needed to hold wout*wout pixels of dsp_no channel planes.
  function automatic int fire_addr_w(input int wout, input int dsp_no);
    return $clog2(wout * wout * dsp_no);
  endfunction

endpackage

// File: rtl/fire_ofm_addr_gen.sv
// Channel/pixel counters and the channel-planar OFM address accumulator.
// The address steps by one plane (WOUT*WOUT) per channel, so no multiplier
// is needed; a new pixel reloads the accumulator with its pixel index.
module fire_ofm_addr_gen #(
  parameter int DSP_NO = 128,
  parameter int WOUT   = 32,
  parameter int ADDR_W = 17
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       clear,
  input  logic                                       start,
  input  logic                                       restart,
  input  logic                                       step,
  input  logic                                       advance,
  output logic [((DSP_NO > 1) ? $clog2(DSP_NO) : 1)-1:0] ch_cnt,
  output logic                                       last_pix,
  output logic [ADDR_W-1:0]                          addr
);

  localparam int NPIX  = WOUT * WOUT;
  localparam int PIX_W = $clog2(NPIX + 1);
  localparam logic [ADDR_W-1:0] PLANE = ADDR_W'(NPIX);

  logic [PIX_W-1:0] pix_cnt;
  logic [PIX_W-1:0] pix_next;

  assign pix_next = pix_cnt + 1'b1;
  // High when finishing the current pixel completes the whole feature map.
  assign last_pix = (pix_next == PIX_W'(NPIX));

  // Counter and accumulator update; clear has priority over every other op.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch_cnt  <= '0;
      pix_cnt <= '0;
      addr    <= '0;
    end else if (clear) begin
      ch_cnt  <= '0;
      pix_cnt <= '0;
      addr    <= '0;
    end else if (start) begin
      ch_cnt <= '0;
      addr   <= ADDR_W'(pix_cnt);
    end else if (restart) begin
      ch_cnt  <= '0;
      pix_cnt <= pix_next;
      addr    <= ADDR_W'(pix_next);
    end else if (step) begin
      ch_cnt <= ch_cnt + 1'b1;
      addr   <= addr + PLANE;
    end else if (advance) begin
      ch_cnt  <= '0;
      pix_cnt <= pix_next;
    end
  end

endmodule

// File: rtl/fire_ofm_writer.sv
// OFM writer: captures one DSP_NO-wide output pixel, serialises it into the
// single-port OFM RAM in channel-planar order (one word per cycle), and
// raises ram_feedback once the full map is stored and the layer has finished.
//
// Input handshake: ofm_sample_i is a valid-only pulse with no ready. A sample
// is accepted in IDLE or in the final DRAIN cycle of the previous pixel (so
// bursts can run back to back); anywhere else it is dropped and overrun_o
// latches until clear_i or reset. The write port is valid-only as well:
// every cycle with ram_we_o high is one committed RAM write.
module fire_ofm_writer
  import fire_pkg::*;
#(
  parameter int WIDTH  = OFM_WIDTH,
  parameter int DSP_NO = 128,
  parameter int WOUT   = 32,
  parameter int ADDR_W = fire_addr_w(WOUT, DSP_NO)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ofm_sample_i,
  input  logic [WIDTH-1:0]    ofm_i [0:DSP_NO-1],
  input  logic                layer_finish_i,
  input  logic                clear_i,
  output logic                ram_we_o,
  output logic [ADDR_W-1:0]   ram_addr_o,
  output logic [WIDTH-1:0]    ram_data_o,
  output logic                ram_feedback_o,
  output logic                busy_o,
  output logic                overrun_o,
  output writer_state_e       dbg_state
);

  localparam int CH_W = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;

  writer_state_e    state;
  logic [WIDTH-1:0] buffer [0:DSP_NO-1];
  logic [CH_W-1:0]  ch_cnt;
  logic [CH_W-1:0]  ch_next;
  logic             last_pix;
  logic             last_ch;
  logic             cap_idle;
  logic             cap_last;
  logic             capture;
  logic             drop;
  logic             step;
  logic             advance;

  assign dbg_state = state;

  // Decode capture/drop and the counter operation for this cycle.
  always_comb begin
    last_ch  = (state == DRAIN) && (ch_cnt == CH_W'(DSP_NO - 1));
    cap_idle = ofm_sample_i && !clear_i && (state == IDLE);
    // No back-to-back capture once the map is complete: pix_cnt must not pass WOUT**2.
    cap_last = ofm_sample_i && !clear_i && last_ch && !last_pix;
    capture  = cap_idle || cap_last;
    drop     = ofm_sample_i && !clear_i && !capture;
    step     = !clear_i && (state == DRAIN) && !last_ch;
    advance  = !clear_i && last_ch && !cap_last;
    ch_next  = ch_cnt + 1'b1;
  end

  fire_ofm_addr_gen #(
    .DSP_NO (DSP_NO),
    .WOUT   (WOUT),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear_i),
    .start    (cap_idle),
    .restart  (cap_last),
    .step     (step),
    .advance  (advance),
    .ch_cnt   (ch_cnt),
    .last_pix (last_pix),
    .addr     (ram_addr_o)
  );

  // Capture buffer; deliberately not reset, its contents are only read after a capture.
  always_ff @(posedge clk) begin
    if (capture) buffer <= ofm_i;
  end

  // Writer FSM with registered RAM strobe, data, feedback, busy and overrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      ram_we_o       <= 1'b0;
      ram_data_o     <= '0;
      ram_feedback_o <= 1'b0;
      busy_o         <= 1'b0;
      overrun_o      <= 1'b0;
    end else begin
      ram_feedback_o <= 1'b0;
      if (clear_i) begin
        state     <= IDLE;
        ram_we_o  <= 1'b0;
        busy_o    <= 1'b0;
        overrun_o <= 1'b0;
      end else begin
        if (drop) overrun_o <= 1'b1;
        case (state)
          IDLE: begin
            if (cap_idle) begin
              state      <= DRAIN;
              ram_we_o   <= 1'b1;
              busy_o     <= 1'b1;
              ram_data_o <= ofm_i[0];
            end
          end
          DRAIN: begin
            if (!last_ch) begin
              ram_data_o <= buffer[ch_next];
            end else if (cap_last) begin
              ram_data_o <= ofm_i[0];
            end else begin
              ram_we_o <= 1'b0;
              busy_o   <= 1'b0;
              state    <= last_pix ? WAIT_FIN : IDLE;
            end
          end
          WAIT_FIN: begin
            if (layer_finish_i) begin
              state          <= DONE;
              ram_feedback_o <= 1'b1;
            end
          end
          DONE: begin
            state <= DONE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fire_ofm_writer.sv
// Bench for fire_ofm_writer at a reduced geometry (16 channels, 8x8 map).
// Expected RAM writes are queued when a sample is driven and checked in
// order by a write monitor; each scenario task checks its own timing points.
module tb_fire_ofm_writer;
  import fire_pkg::*;

  localparam int W  = 16;
  localparam int DN = 16;
  localparam int WO = 8;
  localparam int NP = WO * WO;
  localparam int AW = $clog2(NP * DN);
  localparam int SP = 29;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ofm_sample_i = 1'b0;
  logic layer_finish_i = 1'b0;
  logic clear_i = 1'b0;
  logic [W-1:0] ofm_i [0:DN-1];
  logic ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [W-1:0] ram_data_o;
  logic ram_feedback_o;
  logic busy_o;
  logic overrun_o;
  writer_state_e dbg_state;

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  logic [AW+W-1:0] exp_q[$];
  logic [AW+W-1:0] exp_v;
  logic [W-1:0] dat [0:DN-1];
  int we_run = 0;
  int last_run = 0;
  int fb_cnt = 0;
  int fb_cyc = 0;
  int wf_cyc = 0;
  logic [AW-1:0] last_addr = '0;
  writer_state_e prev_state = IDLE;

  fire_ofm_writer #(
    .WIDTH  (W),
    .DSP_NO (DN),
    .WOUT   (WO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ofm_sample_i   (ofm_sample_i),
    .ofm_i          (ofm_i),
    .layer_finish_i (layer_finish_i),
    .clear_i        (clear_i),
    .ram_we_o       (ram_we_o),
    .ram_addr_o     (ram_addr_o),
    .ram_data_o     (ram_data_o),
    .ram_feedback_o (ram_feedback_o),
    .busy_o         (busy_o),
    .overrun_o      (overrun_o),
    .dbg_state      (dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // write monitor and scoreboard
  always @(negedge clk) begin
    if (rst) begin
      if (ram_we_o) begin
        we_run++;
        last_addr = ram_addr_o;
        tests++;
        if (exp_q.size() == 0) begin
          failed++;
          $display("FAIL sb_extra_write got addr=%0d data=%0h with nothing expected", ram_addr_o, ram_data_o);
        end else begin
          exp_v = exp_q.pop_front();
          if ({ram_addr_o, ram_data_o} !== exp_v) begin
            failed++;
            $display("FAIL sb_write got addr=%0d data=%0h expected addr=%0d data=%0h",
                     ram_addr_o, ram_data_o, exp_v[AW+W-1:W], exp_v[W-1:0]);
          end
        end
      end else begin
        if (we_run != 0) last_run = we_run;
        we_run = 0;
      end
      if (ram_feedback_o) begin
        fb_cnt++;
        fb_cyc = cyc;
      end
      if (dbg_state == WAIT_FIN && prev_state != WAIT_FIN) wf_cyc = cyc;
      prev_state = dbg_state;
    end else begin
      we_run = 0;
    end
  end

  // driver helpers
  task automatic fill_random();
    for (int k = 0; k < DN; k++) dat[k] = W'($urandom_range(0, 65535));
  endtask

  // Called at a negedge; drives a one-cycle sample and returns at the next negedge.
  task automatic send(input bit accept, input int pix);
    for (int k = 0; k < DN; k++) ofm_i[k] = dat[k];
    ofm_sample_i = 1'b1;
    if (accept)
      for (int k = 0; k < DN; k++) exp_q.push_back({AW'(k * NP + pix), dat[k]});
    @(negedge clk);
    ofm_sample_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (ram_we_o !== 1'b0) begin failed++; $display("FAIL reset_we got %b expected 0", ram_we_o); end
    tests++; if (ram_addr_o !== '0) begin failed++; $display("FAIL reset_addr got %0d expected 0", ram_addr_o); end
    tests++; if (ram_data_o !== '0) begin failed++; $display("FAIL reset_data got %0h expected 0", ram_data_o); end
    tests++; if (ram_feedback_o !== 1'b0) begin failed++; $display("FAIL reset_fb got %b expected 0", ram_feedback_o); end
    tests++; if (busy_o !== 1'b0) begin failed++; $display("FAIL reset_busy got %b expected 0", busy_o); end
    tests++; if (overrun_o !== 1'b0) begin failed++; $display("FAIL reset_overrun got %b expected 0", overrun_o); end
    tests++; if (dbg_state !== IDLE) begin failed++; $display("FAIL reset_state got %0d expected %0d", dbg_state, IDLE); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    for (int k = 0; k < DN; k++) dat[k] = W'(k + 1);
    send(1'b1, 0);
    tests++;
    if (ram_we_o !== 1'b1 || ram_addr_o !== AW'(0) || ram_data_o !== W'(1) || busy_o !== 1'b1) begin
      failed++;
      $display("FAIL single_first_write got we=%b addr=%0d data=%0h busy=%b expected 1 0 1 1",
               ram_we_o, ram_addr_o, ram_data_o, busy_o);
    end
    repeat (DN) @(negedge clk);
    tests++;
    if (ram_we_o !== 1'b0 || busy_o !== 1'b0 || dbg_state !== IDLE) begin
      failed++;
      $display("FAIL single_end got we=%b busy=%b state=%0d expected 0 0 %0d", ram_we_o, busy_o, dbg_state, IDLE);
    end
    @(negedge clk);
    tests++; if (last_run !== DN) begin failed++; $display("FAIL single_burst_len got %0d expected %0d", last_run, DN); end
    tests++; if (exp_q.size() !== 0) begin failed++; $display("FAIL single_drained got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    for (int p = 1; p <= 4; p++) begin
      fill_random();
      send(1'b1, p);
      repeat (DN + 4) @(negedge clk);
    end
    fill_random();
    send(1'b1, 5);
    repeat (DN - 1) @(negedge clk);
    fill_random();
    send(1'b1, 6);
    repeat (DN + 2) @(negedge clk);
    tests++; if (last_run !== 2 * DN) begin failed++; $display("FAIL b2b_burst_len got %0d expected %0d", last_run, 2 * DN); end
    tests++; if (overrun_o !== 1'b0) begin failed++; $display("FAIL b2b_overrun got %b expected 0", overrun_o); end
    tests++; if (last_addr !== AW'((DN - 1) * NP + 6)) begin failed++; $display("FAIL b2b_last_addr got %0d expected %0d", last_addr, (DN - 1) * NP + 6); end
    tests++; if (exp_q.size() !== 0) begin failed++; $display("FAIL b2b_drained got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_overrun();
    fill_random();
    send(1'b1, 7);
    repeat (DN / 2) @(negedge clk);
    fill_random();
    send(1'b0, 0);
    tests++; if (overrun_o !== 1'b1) begin failed++; $display("FAIL ovr_set got %b expected 1", overrun_o); end
    repeat (DN + 4) @(negedge clk);
    tests++; if (last_run !== DN) begin failed++; $display("FAIL ovr_burst_len got %0d expected %0d", last_run, DN); end
    fill_random();
    send(1'b1, 8);
    repeat (DN + 4) @(negedge clk);
    tests++; if (overrun_o !== 1'b1) begin failed++; $display("FAIL ovr_sticky got %b expected 1", overrun_o); end
    tests++; if (exp_q.size() !== 0) begin failed++; $display("FAIL ovr_drained got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_drain();
    fill_random();
    send(1'b1, 9);
    repeat (DN / 2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    tests++;
    if (ram_we_o !== 1'b0 || busy_o !== 1'b0 || overrun_o !== 1'b0 || ram_addr_o !== '0) begin
      failed++;
      $display("FAIL rst_async got we=%b busy=%b ovr=%b addr=%0d expected 0 0 0 0", ram_we_o, busy_o, overrun_o, ram_addr_o);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    fill_random();
    send(1'b1, 0);
    repeat (DN + 4) @(negedge clk);
    tests++; if (last_run !== DN) begin failed++; $display("FAIL rst_restart_len got %0d expected %0d", last_run, DN); end
    tests++; if (exp_q.size() !== 0) begin failed++; $display("FAIL rst_drained got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_full_layer();
    for (int p = 1; p < NP; p++) begin
      fill_random();
      send(1'b1, p);
      if (p == NP - 24) layer_finish_i = 1'b1;
      repeat (SP - 1) @(negedge clk);
    end
    tests++; if (fb_cnt !== 1) begin failed++; $display("FAIL full_fb_count got %0d expected 1", fb_cnt); end
    tests++; if (fb_cyc - wf_cyc !== 1) begin failed++; $display("FAIL full_fb_delay got %0d expected 1", fb_cyc - wf_cyc); end
    tests++; if (last_addr !== AW'(NP * DN - 1)) begin failed++; $display("FAIL full_last_addr got %0d expected %0d", last_addr, NP * DN - 1); end
    tests++; if (dbg_state !== DONE) begin failed++; $display("FAIL full_state got %0d expected %0d", dbg_state, DONE); end
    tests++; if (exp_q.size() !== 0) begin failed++; $display("FAIL full_drained got %0d pending expected 0", exp_q.size()); end
    layer_finish_i = 1'b0;
    fill_random();
    send(1'b0, 0);
    repeat (4) @(negedge clk);
    tests++; if (overrun_o !== 1'b1) begin failed++; $display("FAIL done_drop_overrun got %b expected 1", overrun_o); end
    tests++; if (dbg_state !== DONE || fb_cnt !== 1) begin failed++; $display("FAIL done_hold got state=%0d fb=%0d expected %0d 1", dbg_state, fb_cnt, DONE); end
  endtask

  task automatic test_clear_relayer();
    fill_random();
    for (int k = 0; k < DN; k++) ofm_i[k] = dat[k];
    clear_i = 1'b1;
    ofm_sample_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    ofm_sample_i = 1'b0;
    tests++;
    if (dbg_state !== IDLE || overrun_o !== 1'b0 || ram_we_o !== 1'b0 || busy_o !== 1'b0) begin
      failed++;
      $display("FAIL clear_state got state=%0d ovr=%b we=%b busy=%b expected %0d 0 0 0", dbg_state, overrun_o, ram_we_o, busy_o, IDLE);
    end
    for (int p = 0; p < NP; p++) begin
      fill_random();
      send(1'b1, p);
      repeat (SP - 1) @(negedge clk);
    end
    tests++; if (dbg_state !== WAIT_FIN) begin failed++; $display("FAIL relayer_wait got %0d expected %0d", dbg_state, WAIT_FIN); end
    repeat (5) @(negedge clk);
    tests++; if (dbg_state !== WAIT_FIN || fb_cnt !== 1) begin failed++; $display("FAIL relayer_hold got state=%0d fb=%0d expected %0d 1", dbg_state, fb_cnt, WAIT_FIN); end
    layer_finish_i = 1'b1;
    for (int i = 0; i < 10 && fb_cnt < 2; i++) @(negedge clk);
    tests++; if (fb_cnt !== 2) begin failed++; $display("FAIL relayer_fb got %0d expected 2", fb_cnt); end
    layer_finish_i = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (dbg_state !== DONE || fb_cnt !== 2) begin failed++; $display("FAIL relayer_done got state=%0d fb=%0d expected %0d 2", dbg_state, fb_cnt, DONE); end
    tests++; if (overrun_o !== 1'b0) begin failed++; $display("FAIL relayer_overrun got %b expected 0", overrun_o); end
    tests++; if (exp_q.size() !== 0) begin failed++; $display("FAIL relayer_drained got %0d pending expected 0", exp_q.size()); end
  endtask

  initial begin
    for (int k = 0; k < DN; k++) ofm_i[k] = '0;
    for (int k = 0; k < DN; k++) dat[k] = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_reset_mid_drain();
    test_full_layer();
    test_clear_relayer();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // run-time bound
  initial begin
    #1000000;
    tests++;
    failed++;
    $display("FAIL watchdog expired at cycle %0d expected completion", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
